// File: rtl/reorder_buffer.sv
// Reorder buffer: hands out slots in program order, collects completions, and retires
// up to MACHINE_WIDTH finished head entries per cycle, flushing on a taken branch.
module reorder_buffer #(
    parameter int ROB_DEPTH     = 16,
    parameter int MACHINE_WIDTH = 2,
    parameter int WB_NUM        = 2,
    parameter int CREG_W        = 5,
    parameter int PREG_W        = 6
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [MACHINE_WIDTH-1:0]                  alloc_valid,
    input  logic [MACHINE_WIDTH*CREG_W-1:0]           alloc_dst,
    input  logic [MACHINE_WIDTH*PREG_W-1:0]           alloc_preg,
    output logic                                      alloc_ready,
    output logic [MACHINE_WIDTH*$clog2(ROB_DEPTH)-1:0] rob_addr_new,
    input  logic [WB_NUM-1:0]                         wb_valid,
    input  logic [WB_NUM*$clog2(ROB_DEPTH)-1:0]       wb_rob_addr,
    input  logic [WB_NUM*32-1:0]                      wb_data,
    input  logic [WB_NUM-1:0]                         wb_br_taken,
    input  logic [WB_NUM*32-1:0]                      wb_pcbranch,
    output logic [MACHINE_WIDTH-1:0]                  retire_valid,
    output logic [MACHINE_WIDTH*CREG_W-1:0]           retire_dst,
    output logic [MACHINE_WIDTH*PREG_W-1:0]           retire_preg,
    output logic [MACHINE_WIDTH*32-1:0]               retire_data,
    output logic                                      branch_taken,
    output logic [31:0]                               pcbranch
);
    localparam int AW = $clog2(ROB_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ROB_DEPTH-1:0] valid_q, valid_d, done_q, done_d, br_q, br_d;
    logic [CREG_W-1:0] dst_q  [ROB_DEPTH];
    logic [CREG_W-1:0] dst_d  [ROB_DEPTH];
    logic [PREG_W-1:0] preg_q [ROB_DEPTH];
    logic [PREG_W-1:0] preg_d [ROB_DEPTH];
    logic [31:0]       data_q [ROB_DEPTH];
    logic [31:0]       data_d [ROB_DEPTH];
    logic [31:0]       pc_q   [ROB_DEPTH];
    logic [31:0]       pc_d   [ROB_DEPTH];

    logic [AW-1:0] lane_addr [MACHINE_WIDTH];
    logic [AW-1:0] ret_idx   [MACHINE_WIDTH];
    logic [AW-1:0] alloc_ptr;
    logic [AW-1:0] wb_idx;
    logic [CW-1:0] n_alloc, n_ret;
    logic          retire_ok;

    // Allocation is all-or-nothing: alloc_ready depends only on the current count,
    // so renaming may present lanes every cycle and holds them while alloc_ready is low.
    always_comb begin
        alloc_ready  = (CW'(ROB_DEPTH) - count_q) >= CW'(MACHINE_WIDTH);
        alloc_ptr    = tail_q;
        n_alloc      = '0;
        rob_addr_new = '0;
        for (int l = 0; l < MACHINE_WIDTH; l++) begin
            lane_addr[l] = alloc_ptr;
            rob_addr_new[l*AW +: AW] = alloc_ptr;
            if (alloc_valid[l]) begin
                alloc_ptr = alloc_ptr + AW'(1);
                n_alloc   = n_alloc + CW'(1);
            end
        end
    end

    // Retire lanes form a prefix of the head; a retiring branch ends the prefix.
    always_comb begin
        retire_valid = '0;
        retire_dst   = '0;
        retire_preg  = '0;
        retire_data  = '0;
        branch_taken = 1'b0;
        pcbranch     = '0;
        n_ret        = '0;
        retire_ok    = 1'b1;
        for (int l = 0; l < MACHINE_WIDTH; l++) begin
            ret_idx[l] = head_q + AW'(l);
            if (retire_ok && valid_q[ret_idx[l]] && done_q[ret_idx[l]]) begin
                retire_valid[l]              = 1'b1;
                retire_dst[l*CREG_W +: CREG_W] = dst_q[ret_idx[l]];
                retire_preg[l*PREG_W +: PREG_W] = preg_q[ret_idx[l]];
                retire_data[l*32 +: 32]      = data_q[ret_idx[l]];
                n_ret                        = n_ret + CW'(1);
                if (br_q[ret_idx[l]]) begin
                    branch_taken = 1'b1;
                    pcbranch     = pc_q[ret_idx[l]];
                    retire_ok    = 1'b0;
                end
            end else begin
                retire_ok = 1'b0;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        br_d    = br_q;
        dst_d   = dst_q;
        preg_d  = preg_q;
        data_d  = data_q;
        pc_d    = pc_q;
        wb_idx  = '0;
        // Ascending port order lets the higher port overwrite on an address collision.
        for (int p = 0; p < WB_NUM; p++) begin
            wb_idx = wb_rob_addr[p*AW +: AW];
            if (wb_valid[p] && valid_q[wb_idx]) begin
                done_d[wb_idx] = 1'b1;
                data_d[wb_idx] = wb_data[p*32 +: 32];
                br_d[wb_idx]   = wb_br_taken[p];
                pc_d[wb_idx]   = wb_pcbranch[p*32 +: 32];
            end
        end
        for (int l = 0; l < MACHINE_WIDTH; l++) begin
            if (retire_valid[l]) begin
                valid_d[ret_idx[l]] = 1'b0;
                done_d[ret_idx[l]]  = 1'b0;
                br_d[ret_idx[l]]    = 1'b0;
            end
        end
        for (int l = 0; l < MACHINE_WIDTH; l++) begin
            if (alloc_ready && alloc_valid[l]) begin
                valid_d[lane_addr[l]] = 1'b1;
                done_d[lane_addr[l]]  = 1'b0;
                br_d[lane_addr[l]]    = 1'b0;
                dst_d[lane_addr[l]]   = alloc_dst[l*CREG_W +: CREG_W];
                preg_d[lane_addr[l]]  = alloc_preg[l*PREG_W +: PREG_W];
            end
        end
        head_d  = head_q + n_ret[AW-1:0];
        tail_d  = alloc_ready ? alloc_ptr : tail_q;
        count_d = alloc_ready ? (count_q + n_alloc - n_ret) : (count_q - n_ret);
        if (branch_taken) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
            br_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            br_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            br_q    <= br_d;
        end
    end

    // Payload is only observed through valid/done entries, so it needs no reset.
    always_ff @(posedge clk) begin
        dst_q  <= dst_d;
        preg_q <= preg_d;
        data_q <= data_d;
        pc_q   <= pc_d;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a driver issues vectors and queues the retirements
// they must produce; a monitor pops and compares whenever the buffer retires.
module tb_reorder_buffer;
    localparam int MW = 2;
    localparam int WB = 2;
    localparam int AW = 4;
    localparam int EW = 5 + 6 + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [MW-1:0] alloc_valid;
    logic [MW*5-1:0] alloc_dst;
    logic [MW*6-1:0] alloc_preg;
    logic          alloc_ready;
    logic [MW*AW-1:0] rob_addr_new;
    logic [WB-1:0] wb_valid;
    logic [WB*AW-1:0] wb_rob_addr;
    logic [WB*32-1:0] wb_data;
    logic [WB-1:0] wb_br_taken;
    logic [WB*32-1:0] wb_pcbranch;
    logic [MW-1:0] retire_valid;
    logic [MW*5-1:0] retire_dst;
    logic [MW*6-1:0] retire_preg;
    logic [MW*32-1:0] retire_data;
    logic          branch_taken;
    logic [31:0]   pcbranch;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   exp_br_q[$];
    logic [EW-1:0] mon_e;
    logic [31:0]   mon_pc;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_preg(alloc_preg),
        .alloc_ready(alloc_ready), .rob_addr_new(rob_addr_new),
        .wb_valid(wb_valid), .wb_rob_addr(wb_rob_addr), .wb_data(wb_data),
        .wb_br_taken(wb_br_taken), .wb_pcbranch(wb_pcbranch),
        .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_preg(retire_preg),
        .retire_data(retire_data), .branch_taken(branch_taken), .pcbranch(pcbranch)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [4:0] d, input logic [5:0] p,
                                          input logic [31:0] data);
        return {d, p, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid = '0;
        wb_valid    = '0;
        wb_br_taken = '0;
    endtask

    task automatic set_alloc(input logic [1:0] v, input logic [4:0] d0, input logic [5:0] p0,
                             input logic [4:0] d1, input logic [5:0] p1);
        alloc_valid = v;
        alloc_dst   = {d1, d0};
        alloc_preg  = {p1, p0};
    endtask

    task automatic set_wb(input int port, input logic [3:0] addr, input logic [31:0] data,
                          input logic br, input logic [31:0] pc);
        wb_valid[port]             = 1'b1;
        wb_rob_addr[port*AW +: AW] = addr;
        wb_data[port*32 +: 32]     = data;
        wb_br_taken[port]          = br;
        wb_pcbranch[port*32 +: 32] = pc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Monitor: every retiring lane and every redirect must match the head of its queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int l = 0; l < MW; l++) begin
                if (retire_valid[l] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL retire_unexpected lane=%0d actual=%0h required=none",
                                 l, {retire_dst[l*5 +: 5], retire_preg[l*6 +: 6], retire_data[l*32 +: 32]});
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("retire_entry", 64'({retire_dst[l*5 +: 5], retire_preg[l*6 +: 6],
                            retire_data[l*32 +: 32]}), 64'(mon_e));
                    end
                end
            end
            if (branch_taken === 1'b1) begin
                if (exp_br_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL redirect_unexpected actual=%0h required=none", pcbranch);
                end else begin
                    mon_pc = exp_br_q.pop_front();
                    chk("redirect_pc", 64'(pcbranch), 64'(mon_pc));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        alloc_valid = '0;
        alloc_dst   = '0;
        alloc_preg  = '0;
        wb_valid    = '0;
        wb_rob_addr = '0;
        wb_data     = '0;
        wb_br_taken = '0;
        wb_pcbranch = '0;

        // Reset values, with both lanes requesting.
        tick();
        tick();
        alloc_valid = 2'b11;
        @(negedge clk);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_rob_addr_new", 64'(rob_addr_new), 64'h10);
        chk("rst_retire_valid", 64'(retire_valid), 64'd0);
        chk("rst_branch_taken", 64'(branch_taken), 64'd0);
        chk("rst_pcbranch", 64'(pcbranch), 64'd0);
        tick();
        reset = 1'b0;

        // Fill with paired allocations: slot s holds dst=s, preg=16+s.
        for (int k = 0; k < 8; k++) begin
            set_alloc(2'b11, 5'(2*k), 6'(16 + 2*k), 5'(2*k + 1), 6'(17 + 2*k));
            @(negedge clk);
            chk("fill_ready", 64'(alloc_ready), 64'd1);
            chk("fill_addr", 64'(rob_addr_new), 64'({4'(2*k + 1), 4'(2*k)}));
            tick();
        end

        // Full: allocation refused, tail back at 0; complete the head meanwhile.
        set_alloc(2'b11, 5'd1, 6'd1, 5'd1, 6'd1);
        set_wb(0, 4'd0, 32'hA000_0000, 1'b0, 32'h0);
        exp_q.push_back(ent(5'd0, 6'd16, 32'hA000_0000));
        @(negedge clk);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        chk("full_tail", 64'(rob_addr_new[3:0]), 64'd0);
        tick();
        set_alloc(2'b11, 5'd1, 6'd1, 5'd1, 6'd1);
        @(negedge clk);
        chk("full_retire_ready", 64'(alloc_ready), 64'd0);
        chk("full_retire_valid", 64'(retire_valid), 64'b01);
        tick();
        set_alloc(2'b11, 5'd1, 6'd1, 5'd1, 6'd1);
        set_wb(1, 4'd1, 32'hA1A1_A1A1, 1'b0, 32'h0);
        exp_q.push_back(ent(5'd1, 6'd17, 32'hA1A1_A1A1));
        @(negedge clk);
        chk("one_free_ready", 64'(alloc_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("one_free_retire", 64'(retire_valid), 64'b01);
        chk("one_free_ready2", 64'(alloc_ready), 64'd0);
        tick();
        set_alloc(2'b11, 5'd20, 6'd40, 5'd21, 6'd41);
        @(negedge clk);
        chk("wrap_ready", 64'(alloc_ready), 64'd1);
        chk("wrap_addr", 64'(rob_addr_new), 64'h10);
        tick();
        do_reset();

        // Single lane then pair: slots 0, then 1 and 2.
        set_alloc(2'b01, 5'd3, 6'd33, 5'd0, 6'd0);
        @(negedge clk);
        chk("single_addr", 64'(rob_addr_new[3:0]), 64'd0);
        tick();
        set_alloc(2'b11, 5'd4, 6'd34, 5'd5, 6'd35);
        @(negedge clk);
        chk("pair_addr", 64'(rob_addr_new), 64'h21);
        tick();
        @(negedge clk);
        chk("tail_after_three", 64'(rob_addr_new[3:0]), 64'd3);
        tick();

        // Out-of-order completion: slot1 first, then slot0, both retire together.
        set_wb(0, 4'd1, 32'h1111_1111, 1'b0, 32'h0);
        tick();
        set_wb(1, 4'd0, 32'h2222_2222, 1'b0, 32'h0);
        exp_q.push_back(ent(5'd3, 6'd33, 32'h2222_2222));
        exp_q.push_back(ent(5'd4, 6'd34, 32'h1111_1111));
        @(negedge clk);
        chk("ooo_wait", 64'(retire_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("ooo_retire_both", 64'(retire_valid), 64'b11);
        tick();

        // Same-slot double writeback: port 1 wins.
        set_wb(0, 4'd2, 32'hAAAA_0000, 1'b0, 32'h0);
        set_wb(1, 4'd2, 32'hBBBB_0000, 1'b0, 32'h0);
        exp_q.push_back(ent(5'd5, 6'd35, 32'hBBBB_0000));
        tick();
        @(negedge clk);
        chk("dual_wb_retire", 64'(retire_valid), 64'b01);
        tick();

        // Writeback to an unallocated slot must not mark it done.
        set_wb(0, 4'd3, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tick();
        set_alloc(2'b01, 5'd7, 6'd37, 5'd0, 6'd0);
        @(negedge clk);
        chk("invalid_wb_slot", 64'(rob_addr_new[3:0]), 64'd3);
        tick();
        @(negedge clk);
        chk("invalid_wb_ignored", 64'(retire_valid), 64'd0);
        tick();
        do_reset();

        // Taken branch at head: retires alone, redirects, flushes.
        set_alloc(2'b11, 5'd10, 6'd50, 5'd11, 6'd51);
        tick();
        set_alloc(2'b11, 5'd12, 6'd52, 5'd13, 6'd53);
        tick();
        set_wb(0, 4'd2, 32'h33, 1'b0, 32'h0);
        set_wb(1, 4'd3, 32'h44, 1'b0, 32'h0);
        tick();
        set_wb(0, 4'd0, 32'h0000_AAAA, 1'b1, 32'hBFC0_0380);
        set_wb(1, 4'd1, 32'h0000_5555, 1'b0, 32'h0);
        exp_q.push_back(ent(5'd10, 6'd50, 32'h0000_AAAA));
        exp_br_q.push_back(32'hBFC0_0380);
        @(negedge clk);
        chk("br_wait", 64'(retire_valid), 64'd0);
        tick();
        set_alloc(2'b11, 5'd1, 6'd1, 5'd1, 6'd1);
        @(negedge clk);
        chk("br_retire_valid", 64'(retire_valid), 64'b01);
        chk("br_taken", 64'(branch_taken), 64'd1);
        chk("br_pc", 64'(pcbranch), 64'hBFC0_0380);
        tick();
        @(negedge clk);
        chk("flush_retire", 64'(retire_valid), 64'd0);
        chk("flush_branch", 64'(branch_taken), 64'd0);
        chk("flush_tail", 64'(rob_addr_new[3:0]), 64'd0);
        chk("flush_ready", 64'(alloc_ready), 64'd1);
        tick();
        tick();

        // Reset mid-operation drops a same-cycle writeback and all entries.
        set_alloc(2'b11, 5'd9, 6'd9, 5'd8, 6'd8);
        tick();
        set_wb(0, 4'd0, 32'h1234_5678, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_retire", 64'(retire_valid), 64'd0);
        chk("midrst_tail", 64'(rob_addr_new[3:0]), 64'd0);
        tick();
        tick();

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("exp_br_q_drained", 64'(exp_br_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
